fetch_req_ctrl: RTL and testbench

//  Fetch request controller sitting directly downstream of the next-PC unit and

---
 rtl/fetch_req_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_req_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_req_ctrl.sv
// fetch_req_ctrl: turns fetch addresses into I$ requests, tracks them in order and kills them on redirect
package fetch_req_ctrl_pkg;
    typedef struct packed {
        int unsigned VLEN;
        int unsigned FETCH_WIDTH;
        int unsigned FETCH_ALIGN_BITS;
    } cva6_cfg_t;
    localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32, FETCH_WIDTH: 32, FETCH_ALIGN_BITS: 2};
endpackage

module fetch_req_ctrl #(
    parameter fetch_req_ctrl_pkg::cva6_cfg_t CVA6Cfg = fetch_req_ctrl_pkg::cva6_cfg_empty,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned VLEN = CVA6Cfg.VLEN,
    localparam int unsigned FETCH_WIDTH = CVA6Cfg.FETCH_WIDTH,
    localparam int unsigned FW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [VLEN-1:0]        fetch_addr_i,
    input  logic                   flush_i,
    input  logic [FW-1:0]          fifo_free_i,
    output logic                   icache_req_valid_o,
    input  logic                   icache_req_ready_i,
    output logic [VLEN-1:0]        icache_req_addr_o,
    output logic                   icache_kill_o,
    input  logic                   icache_rsp_valid_i,
    input  logic [FETCH_WIDTH-1:0] icache_rsp_data_i,
    input  logic                   icache_rsp_ex_i,
    output logic                   if_ready_o,
    output logic                   fetch_valid_o,
    output logic [VLEN-1:0]        fetch_addr_o,
    output logic [FETCH_WIDTH-1:0] fetch_data_o,
    output logic                   fetch_ex_o,
    output logic                   busy_o
);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned XW = (CW + 1 > FW) ? CW + 1 : FW;
    localparam logic [VLEN-1:0] ALIGN_MASK = (VLEN'(1) << CVA6Cfg.FETCH_ALIGN_BITS) - VLEN'(1);

    logic [VLEN-1:0]            addr_q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] killed_q;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]              total_q, live_q;
    logic [VLEN-1:0]            aligned_addr;
    logic                       push, pop, head_live, deliver;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit check counts only live entries: killed blocks never reach the queue
    always_comb begin
        aligned_addr       = fetch_addr_i & ~ALIGN_MASK;
        icache_req_addr_o  = rst_i ? '0 : aligned_addr;
        icache_req_valid_o = !rst_i && !flush_i && (total_q < CW'(MAX_OUTSTANDING)) &&
                             (XW'(live_q) + XW'(1) <= XW'(fifo_free_i));
        push               = icache_req_valid_o && icache_req_ready_i;
        if_ready_o         = push;
        icache_kill_o      = !rst_i && flush_i && (total_q != '0);
        pop                = icache_rsp_valid_i && (total_q != '0);
        head_live          = pop && !killed_q[rd_ptr_q];
        deliver            = head_live && !flush_i;
        busy_o             = total_q != '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            total_q       <= '0;
            live_q        <= '0;
            killed_q      <= '0;
            fetch_valid_o <= 1'b0;
            fetch_addr_o  <= '0;
            fetch_data_o  <= '0;
            fetch_ex_o    <= 1'b0;
        end else begin
            if (push) begin
                addr_q[wr_ptr_q] <= aligned_addr;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (flush_i) killed_q <= '1;
            else if (push) killed_q[wr_ptr_q] <= 1'b0;
            total_q       <= total_q + CW'(push) - CW'(pop);
            live_q        <= flush_i ? '0 : live_q + CW'(push) - CW'(head_live);
            fetch_valid_o <= deliver;
            if (deliver) begin
                fetch_addr_o <= addr_q[rd_ptr_q];
                fetch_data_o <= icache_rsp_data_i;
                fetch_ex_o   <= icache_rsp_ex_i;
            end
        end
    end

    rsp_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
        icache_rsp_valid_i |-> total_q != '0);
endmodule

// File: tb/tb_fetch_req_ctrl.sv
// tb_fetch_req_ctrl: directed checks of request issue, cap, credit, flush and response delivery
module tb_fetch_req_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, icache_req_ready_i, icache_rsp_valid_i, icache_rsp_ex_i;
    logic [31:0] fetch_addr_i, icache_rsp_data_i;
    logic [2:0]  fifo_free_i;
    logic        icache_req_valid_o, icache_kill_o, if_ready_o, fetch_valid_o, fetch_ex_o, busy_o;
    logic [31:0] icache_req_addr_o, fetch_addr_o, fetch_data_o;
    int          n_assert = 0;
    int          n_fail = 0;
    int          hs;

    fetch_req_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_addr_i(fetch_addr_i), .flush_i(flush_i),
        .fifo_free_i(fifo_free_i), .icache_req_valid_o(icache_req_valid_o),
        .icache_req_ready_i(icache_req_ready_i), .icache_req_addr_o(icache_req_addr_o),
        .icache_kill_o(icache_kill_o), .icache_rsp_valid_i(icache_rsp_valid_i),
        .icache_rsp_data_i(icache_rsp_data_i), .icache_rsp_ex_i(icache_rsp_ex_i),
        .if_ready_o(if_ready_o), .fetch_valid_o(fetch_valid_o), .fetch_addr_o(fetch_addr_o),
        .fetch_data_o(fetch_data_o), .fetch_ex_o(fetch_ex_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; icache_req_ready_i = 1'b1; icache_rsp_valid_i = 1'b1;
        icache_rsp_ex_i = 1'b0; fetch_addr_i = 32'h8000_0006; icache_rsp_data_i = '0;
        fifo_free_i = 3'd4;
        step;
        step;
        #1;
        chk("rst_req_valid", icache_req_valid_o, 0);
        chk("rst_if_ready", if_ready_o, 0);
        chk("rst_req_addr", icache_req_addr_o, 0);
        chk("rst_kill", icache_kill_o, 0);
        chk("rst_fetch_valid", fetch_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        rst_i = 1'b0; icache_rsp_valid_i = 1'b0; icache_req_ready_i = 1'b0;
        #1;
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_fetch_valid", fetch_valid_o, 0);
        step;
        // basic request/response
        icache_req_ready_i = 1'b1;
        #1;
        chk("basic_req_valid", icache_req_valid_o, 1);
        chk("basic_req_addr", icache_req_addr_o, 32'h8000_0004);
        chk("basic_if_ready", if_ready_o, 1);
        step;
        icache_req_ready_i = 1'b0;
        #1;
        chk("basic_busy", busy_o, 1);
        icache_rsp_valid_i = 1'b1; icache_rsp_data_i = 32'h0000_0013;
        #1;
        chk("basic_no_early_valid", fetch_valid_o, 0);
        step;
        icache_rsp_valid_i = 1'b0;
        #1;
        chk("basic_fetch_valid", fetch_valid_o, 1);
        chk("basic_fetch_addr", fetch_addr_o, 32'h8000_0004);
        chk("basic_fetch_data", fetch_data_o, 32'h13);
        chk("basic_fetch_ex", fetch_ex_o, 0);
        chk("basic_busy_done", busy_o, 0);
        step;
        chk("basic_valid_pulse", fetch_valid_o, 0);
        // cap at two outstanding
        hs = 0;
        icache_req_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_addr_i = 32'h8000_0010 + 32'(i) * 32'h10;
            #1;
            if (if_ready_o) hs++;
            step;
        end
        chk("cap_handshakes", hs, 2);
        chk("cap_req_valid", icache_req_valid_o, 0);
        chk("cap_busy", busy_o, 1);
        // response at total=2: pop only
        fetch_addr_i = 32'h8000_0030; icache_rsp_valid_i = 1'b1; icache_rsp_data_i = 32'hA1;
        #1;
        chk("full_rsp_if_ready", if_ready_o, 0);
        step;
        chk("pop1_valid", fetch_valid_o, 1);
        chk("pop1_addr", fetch_addr_o, 32'h8000_0010);
        chk("pop1_data", fetch_data_o, 32'hA1);
        // simultaneous push and pop
        icache_rsp_data_i = 32'hA2;
        #1;
        chk("pushpop_if_ready", if_ready_o, 1);
        step;
        chk("pop2_valid", fetch_valid_o, 1);
        chk("pop2_addr", fetch_addr_o, 32'h8000_0020);
        chk("pop2_data", fetch_data_o, 32'hA2);
        chk("pushpop_busy", busy_o, 1);
        icache_rsp_valid_i = 1'b0; fetch_addr_i = 32'h8000_0040;
        #1;
        chk("refill_req_valid", icache_req_valid_o, 1);
        step;
        icache_req_ready_i = 1'b0;
        #1;
        chk("refill_full", icache_req_valid_o, 0);
        chk("refill_no_valid", fetch_valid_o, 0);
        // flush with two outstanding
        flush_i = 1'b1; icache_req_ready_i = 1'b1; fetch_addr_i = 32'h8000_0100;
        #1;
        chk("flush_kill", icache_kill_o, 1);
        chk("flush_req_valid", icache_req_valid_o, 0);
        chk("flush_if_ready", if_ready_o, 0);
        step;
        flush_i = 1'b0;
        #1;
        chk("post_flush_kill", icache_kill_o, 0);
        icache_rsp_valid_i = 1'b1; icache_rsp_data_i = 32'hB1;
        #1;
        chk("killed1_req_valid", icache_req_valid_o, 0);
        step;
        chk("killed1_dropped", fetch_valid_o, 0);
        icache_rsp_data_i = 32'hB2;
        #1;
        chk("redirect_if_ready", if_ready_o, 1);
        chk("redirect_req_addr", icache_req_addr_o, 32'h8000_0100);
        step;
        chk("killed2_dropped", fetch_valid_o, 0);
        icache_req_ready_i = 1'b0; icache_rsp_data_i = 32'hC1; icache_rsp_ex_i = 1'b1;
        step;
        icache_rsp_valid_i = 1'b0; icache_rsp_ex_i = 1'b0;
        #1;
        chk("redirect_valid", fetch_valid_o, 1);
        chk("redirect_addr", fetch_addr_o, 32'h8000_0100);
        chk("redirect_data", fetch_data_o, 32'hC1);
        chk("redirect_ex", fetch_ex_o, 1);
        chk("redirect_idle", busy_o, 0);
        flush_i = 1'b1;
        #1;
        chk("idle_flush_no_kill", icache_kill_o, 0);
        step;
        flush_i = 1'b0;
        // credit limit
        fifo_free_i = 3'd1; icache_req_ready_i = 1'b1; fetch_addr_i = 32'h8000_0200;
        #1;
        chk("credit_first", icache_req_valid_o, 1);
        step;
        chk("credit_block", icache_req_valid_o, 0);
        step;
        chk("credit_still_block", icache_req_valid_o, 0);
        icache_rsp_valid_i = 1'b1; icache_rsp_data_i = 32'hD1;
        #1;
        chk("credit_rsp_cycle", icache_req_valid_o, 0);
        step;
        icache_rsp_valid_i = 1'b0; icache_req_ready_i = 1'b0;
        #1;
        chk("credit_deliver_addr", fetch_addr_o, 32'h8000_0200);
        chk("credit_resume", icache_req_valid_o, 1);
        // response coinciding with flush
        fifo_free_i = 3'd4; icache_req_ready_i = 1'b1; fetch_addr_i = 32'h8000_0300;
        step;
        icache_req_ready_i = 1'b0;
        step;
        flush_i = 1'b1; icache_rsp_valid_i = 1'b1; icache_rsp_data_i = 32'hE1;
        icache_req_ready_i = 1'b1;
        #1;
        chk("rspflush_kill", icache_kill_o, 1);
        chk("rspflush_if_ready", if_ready_o, 0);
        step;
        flush_i = 1'b0; icache_rsp_valid_i = 1'b0; icache_req_ready_i = 1'b0;
        #1;
        chk("rspflush_dropped", fetch_valid_o, 0);
        chk("rspflush_idle", busy_o, 0);
        step;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
